// File: rtl/gost_block_loader.sv
// rtl/gost_block_loader.sv - byte-serial key/ciphertext loader for the GOST 28147-89 decryption core
//
// Assembles a 256-bit key and 64-bit ciphertext blocks from a byte stream.
// Bytes arrive first-byte-first and land in the most significant position.
// A key is published to key_out only after all 32 bytes have arrived.
// A completed block is held on block_out until the consumer takes it.
//
// Optional feature: define GOST_LOADER_TIMEOUT_EN to abandon a partial key
// or partial block after IDLE_TIMEOUT cycles with no accepted byte.
//
// Parameters:
//   IDLE_TIMEOUT  idle cycles before a partial is abandoned (timeout build only)
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   in_data      stream byte
//   in_is_key    1 = key byte, 0 = ciphertext byte
//   in_valid     in_data / in_is_key valid
//   in_ready     loader accepts a byte this cycle
//   key_out      current key, MSB-first
//   key_valid    a complete key has been loaded since reset
//   block_out    assembled ciphertext block
//   block_valid  block_out holds a complete, unconsumed block
//   out_ready    consumer takes the block
//   err_drop     one-cycle pulse per dropped byte or abandoned partial
module gost_block_loader #(
   parameter int IDLE_TIMEOUT = 1000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   in_data,
   input  logic         in_is_key,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [256:1] key_out,
   output logic         key_valid,
   output logic [64:1]  block_out,
   output logic         block_valid,
   input  logic         out_ready,
   output logic         err_drop
);

   typedef enum logic [1:0] {IDLE, KEY, BLK, HOLD} state_t;

   state_t       state, state_nx;
   logic [4:0]   kcnt, kcnt_nx;
   logic [2:0]   bcnt, bcnt_nx;
   logic [255:0] kshadow, kshadow_nx;
   logic [63:0]  bshift, bshift_nx;
   logic         key_load, blk_load, drop_nx;
   logic         accept;
   logic         timeout;

   assign in_ready = !block_valid && !reset;
   assign accept   = in_valid && in_ready;

`ifdef GOST_LOADER_TIMEOUT_EN
   localparam logic [31:0] TO_LAST = 32'(IDLE_TIMEOUT - 1);
   logic [31:0] tcnt;
   logic        partial;

   assign partial = (state == KEY) || (state == BLK);

   always_ff @(posedge clk) begin
      if (reset || accept || !partial)
         tcnt <= '0;
      else
         tcnt <= tcnt + 32'd1;
   end

   // Fires on the IDLE_TIMEOUT-th consecutive idle edge after the last byte.
   assign timeout = partial && !accept && (tcnt == TO_LAST);
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         kcnt        <= '0;
         bcnt        <= '0;
         kshadow     <= '0;
         bshift      <= '0;
         key_out     <= '0;
         key_valid   <= 1'b0;
         block_out   <= '0;
         block_valid <= 1'b0;
         err_drop    <= 1'b0;
      end else begin
         state    <= state_nx;
         kcnt     <= kcnt_nx;
         bcnt     <= bcnt_nx;
         kshadow  <= kshadow_nx;
         bshift   <= bshift_nx;
         err_drop <= drop_nx;
         if (key_load) begin
            key_out   <= kshadow_nx;
            key_valid <= 1'b1;
         end
         if (blk_load) begin
            block_out   <= bshift_nx;
            block_valid <= 1'b1;
         end else if (state == HOLD && out_ready) begin
            block_valid <= 1'b0;
         end
      end
   end

   always_comb begin
      state_nx   = state;
      kcnt_nx    = kcnt;
      bcnt_nx    = bcnt;
      kshadow_nx = kshadow;
      bshift_nx  = bshift;
      key_load   = 1'b0;
      blk_load   = 1'b0;
      drop_nx    = 1'b0;
      case (state)
         HOLD: begin
            if (out_ready)
               state_nx = IDLE;
         end
         default: begin
            if (accept && in_is_key) begin
               // A key byte mid-block abandons the block and starts a key.
               if (state == BLK)
                  drop_nx = 1'b1;
               kshadow_nx = {kshadow[247:0], in_data};
               if (state == KEY) begin
                  kcnt_nx = kcnt + 5'd1;
                  if (kcnt == 5'd31) begin
                     key_load = 1'b1;
                     state_nx = IDLE;
                  end
               end else begin
                  kcnt_nx  = 5'd1;
                  state_nx = KEY;
               end
            end else if (accept) begin
               // A block byte mid-key abandons the key, then is handled as from IDLE.
               if (state == KEY)
                  drop_nx = 1'b1;
               if (state == BLK) begin
                  bshift_nx = {bshift[55:0], in_data};
                  bcnt_nx   = bcnt + 3'd1;
                  if (bcnt == 3'd7) begin
                     blk_load = 1'b1;
                     state_nx = HOLD;
                  end
               end else if (key_valid) begin
                  bshift_nx = {bshift[55:0], in_data};
                  bcnt_nx   = 3'd1;
                  state_nx  = BLK;
               end else begin
                  drop_nx  = 1'b1;
                  state_nx = IDLE;
               end
            end else if (timeout) begin
               drop_nx  = 1'b1;
               state_nx = IDLE;
            end
         end
      endcase
   end

endmodule

// File: tb/tb_gost_block_loader.sv
// tb/tb_gost_block_loader.sv - self-checking bench for gost_block_loader
module tb_gost_block_loader;

   localparam int TO = 10;

   logic         clk = 1'b0;
   logic         reset;
   logic [7:0]   in_data;
   logic         in_is_key;
   logic         in_valid;
   logic         in_ready;
   logic [256:1] key_out;
   logic         key_valid;
   logic [64:1]  block_out;
   logic         block_valid;
   logic         out_ready;
   logic         err_drop;

   gost_block_loader #(.IDLE_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_is_key(in_is_key),
      .in_valid(in_valid), .in_ready(in_ready), .key_out(key_out),
      .key_valid(key_valid), .block_out(block_out), .block_valid(block_valid),
      .out_ready(out_ready), .err_drop(err_drop)
   );

   always #5 clk = ~clk;

   // Reference model: partial key/block kept as byte queues.
   logic [7:0]   m_kq[$];
   logic [7:0]   m_bq[$];
   logic [256:1] m_key;
   logic         m_kv;
   logic [64:1]  m_blk;
   logic         m_bv;
   logic         m_err;
   int           m_idle;

   int nvec = 0;
   int errs = 0;
   int cnt_bv, cnt_nrdy, cnt_ed;
   logic [64:1] last_blk;

   task automatic model_step();
      logic acc;
      if (reset) begin
         m_kq.delete(); m_bq.delete();
         m_key = '0; m_kv = 0; m_blk = '0; m_bv = 0; m_err = 0; m_idle = 0;
      end else begin
         m_err = 0;
         acc = in_valid && !m_bv;
         if (m_bv) begin
            if (out_ready) m_bv = 0;
         end else if (acc && in_is_key) begin
            if (m_bq.size() != 0) begin m_bq.delete(); m_err = 1; end
            m_kq.push_back(in_data);
            if (m_kq.size() == 32) begin
               m_key = '0;
               foreach (m_kq[i]) m_key = {m_key[248:1], m_kq[i]};
               m_kv = 1;
               m_kq.delete();
            end
         end else if (acc) begin
            if (m_kq.size() != 0) begin m_kq.delete(); m_err = 1; end
            if (!m_kv) m_err = 1;
            else begin
               m_bq.push_back(in_data);
               if (m_bq.size() == 8) begin
                  m_blk = '0;
                  foreach (m_bq[i]) m_blk = {m_blk[56:1], m_bq[i]};
                  m_bv = 1;
                  m_bq.delete();
               end
            end
         end
`ifdef GOST_LOADER_TIMEOUT_EN
         if (acc) m_idle = 0;
         else if (m_kq.size() != 0 || m_bq.size() != 0) begin
            m_idle++;
            if (m_idle == TO) begin
               m_kq.delete(); m_bq.delete(); m_err = 1; m_idle = 0;
            end
         end
`endif
      end
   endtask

   task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
      nvec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare();
      chk("in_ready", 256'(in_ready), 256'(!m_bv && !reset));
      chk("key_valid", 256'(key_valid), 256'(m_kv));
      chk("key_out", key_out, m_key);
      chk("block_valid", 256'(block_valid), 256'(m_bv));
      chk("block_out", 256'(block_out), 256'(m_blk));
      chk("err_drop", 256'(err_drop), 256'(m_err));
      if (block_valid) begin cnt_bv++; last_blk = block_out; end
      if (!in_ready) cnt_nrdy++;
      if (err_drop) cnt_ed++;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic send(logic [7:0] d, logic k);
      in_data = d; in_is_key = k; in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
   endtask

   task automatic clr();
      cnt_bv = 0; cnt_nrdy = 0; cnt_ed = 0; last_blk = '0;
   endtask

   task automatic load_key_00_1f();
      for (int i = 0; i < 32; i++) send(8'(i), 1'b1);
   endtask

   task automatic send_block(logic [63:0] b);
      logic [63:0] t;
      t = b;
      for (int i = 0; i < 8; i++) send(t[63-8*i -: 8], 1'b0);
   endtask

   localparam logic [255:0] KEY_A =
      256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
   localparam logic [255:0] KEY_B =
      256'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAFB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF;

   initial begin
      reset = 1'b1; in_data = '0; in_is_key = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      clr();
      idle(2);
      chk("rst_in_ready", 256'(in_ready), 256'(0));
      chk("rst_key_valid", 256'(key_valid), 256'(0));
      reset = 1'b0;
      idle(1);

      // Key load 00..1F
      load_key_00_1f();
      chk("key_a_valid", 256'(key_valid), 256'(1));
      chk("key_a", key_out, KEY_A);

      // Block with out_ready high: one-cycle valid, one bubble
      clr();
      send_block(64'h0123456789ABCDEF);
      idle(2);
      chk("blk1_value", 256'(last_blk), 256'(64'h0123456789ABCDEF));
      chk("blk1_valid_cycles", 256'(cnt_bv), 256'(1));
      chk("blk1_bubble_cycles", 256'(cnt_nrdy), 256'(1));

      // Block with 5 cycles of backpressure
      clr();
      out_ready = 1'b0;
      send_block(64'h0123456789ABCDEF);
      idle(5);
      out_ready = 1'b1;
      idle(2);
      chk("blk2_value", 256'(last_blk), 256'(64'h0123456789ABCDEF));
      chk("blk2_valid_cycles", 256'(cnt_bv), 256'(6));
      chk("blk2_notready_cycles", 256'(cnt_nrdy), 256'(6));

      // Block bytes before any key
      reset = 1'b1; idle(1); reset = 1'b0;
      clr();
      send_block(64'h0123456789ABCDEF);
      idle(1);
      chk("nokey_drops", 256'(cnt_ed), 256'(8));
      chk("nokey_valid_cycles", 256'(cnt_bv), 256'(0));

      // Partial block abandoned by a new key
      load_key_00_1f();
      clr();
      for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 1'b0);
      for (int i = 0; i < 31; i++) send(8'hA0 + 8'(i), 1'b1);
      chk("key_held", key_out, KEY_A);
      send(8'hBF, 1'b1);
      chk("key_b", key_out, KEY_B);
      chk("abandon_drops", 256'(cnt_ed), 256'(1));

`ifdef GOST_LOADER_TIMEOUT_EN
      // Partial block times out, then a fresh block loads
      clr();
      send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
      idle(TO);
      chk("timeout_drop", 256'(cnt_ed), 256'(1));
      send_block(64'h1122334455667788);
      idle(1);
      chk("post_timeout_blk", 256'(last_blk), 256'(64'h1122334455667788));
      chk("post_timeout_key", key_out, KEY_B);
`endif

      // Reset mid key load
      for (int i = 0; i < 10; i++) send(8'h55, 1'b1);
      reset = 1'b1;
      idle(1);
      chk("midrst_key_valid", 256'(key_valid), 256'(0));
      chk("midrst_key_out", key_out, 256'(0));
      chk("midrst_block_valid", 256'(block_valid), 256'(0));
      reset = 1'b0;
      idle(1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
      $finish;
   end

endmodule
